mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 ADDR_W, 10, memory word-address width (1024-word unified memory).
REQ-002 DATA_W, 32, data word width.
REQ-003 STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-004 Clock and reset: one clock, clk1, with all logic on its rising edge; reset rst_n is asynchronous and active-low.
REQ-005 clk1  in  1  clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 if_req  in  1  fetch read request, held until if_gnt.
REQ-008 if_addr  in  ADDR_W  fetch address (PC).
REQ-009 if_gnt  out  1  fetch granted this cycle.
REQ-010 if_rvalid  out  1  fetch data valid.
REQ-011 if_rdata  out  DATA_W  fetched instruction.
REQ-012 dm_req  in  1  data request (LW/SW), held until dm_gnt.
REQ-013 dm_we  in  1  1 = store, 0 = load.
REQ-014 dm_addr  in  ADDR_W  data address (ALU result).
REQ-015 dm_wdata  in  DATA_W  store data.
REQ-016 dm_gnt  out  1  data request granted this cycle.
REQ-017 dm_rvalid  out  1  load data valid.
REQ-018 dm_rdata  out  DATA_W  load data.
REQ-019 flush  in  1  taken branch: discard fetch traffic.
REQ-020 halted  in  1  pipeline halted: no new grants.
REQ-021 mem_en / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/DATA_W  single-port memory command.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-023 conflict_cnt  out  16  saturating count of cycles with both requests asserted.

Function
REQ-024 The block SHALL grant at most one requester per cycle; the grant is combinational from that cycle's requests and state.
REQ-025 A granted cycle SHALL assert mem_en and drive mem_addr, mem_we and mem_wdata from the winner in the same cycle; mem_we SHALL be 0 for fetch.
REQ-026 Priority: data over fetch, except when starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-027 starve_cnt: +1 per cycle with if_req=1 and if_gnt=0 (saturates at STARVE_MAX); cleared on if_gnt or when if_req=0.
REQ-028 Response FSM, owner register with states NONE/IF/DM: next state is IF on fetch grant, DM on load grant, NONE otherwise (stores and idle cycles).
REQ-029 if_rvalid/dm_rvalid SHALL equal (owner==IF)/(owner==DM), i.e. fixed 1-cycle latency after the grant; rdata outputs SHALL be mem_rdata when the matching rvalid is high, else hold the last value.
REQ-030 Stores SHALL produce no rvalid; a store and a read SHALL never be issued in the same cycle.
REQ-031 flush=1 SHALL block if_gnt in that cycle and SHALL suppress if_rvalid when owner==IF.
REQ-032 halted=1 SHALL block all new grants; an outstanding response SHALL still complete.
REQ-033 conflict_cnt SHALL increment when if_req & dm_req, and SHALL saturate at 16'hFFFF.
REQ-034 Back-to-back grants SHALL be allowed every cycle with no bubble.

Reset
REQ-035 While rst_n=0, the block SHALL hold owner=NONE, starve_cnt=0, conflict_cnt=0, if_rdata=dm_rdata=0, and all grant, rvalid and mem_* outputs at 0.
REQ-036 Reset asserted mid-operation SHALL discard any outstanding response, with no rvalid issued after release.
REQ-037 Grants SHALL be possible in the first clock after rst_n deasserts.

Structure
REQ-038 The shared package mem_arb_pkg SHALL hold the owner enum (NONE, IF, DM) and the ADDR_W/DATA_W defaults.
REQ-039 The starvation counter SHALL be the single sub-module mem_arb_starve_ctr (inputs req, gnt; output force).

Verification
REQ-040 Fetch only: if_req=1, if_addr=5, mem_rdata=32'h2800000A -> if_gnt in cycle 0, if_rvalid with if_rdata=32'h2800000A in cycle 1.
REQ-041 Conflict: if_req=dm_req=1 for 6 cycles, with dm_we=0 and dm_addr=120 -> dm_gnt in cycles 0-3, if_gnt in cycle 4, dm_gnt in cycle 5; conflict_cnt=6.
REQ-042 Store: dm_req=1, dm_we=1, dm_addr=200, dm_wdata=32'hDEADBEEF -> mem_we=1, mem_addr=200 in the grant cycle; no dm_rvalid follows.
REQ-043 Flush: fetch granted in cycle 0, flush=1 in cycle 1 -> if_rvalid=0 in cycle 1, and no if_gnt in cycle 1 while if_req=1.
REQ-044 Halt: load granted in cycle 0, halted=1 from cycle 1 -> dm_rvalid=1 in cycle 1, and no grants afterwards.
REQ-045 Reset: rst_n=0 in the cycle after a load grant -> dm_rvalid stays 0; all outputs are 0 during reset; a grant is issued in the first cycle after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   owner_e       : which requester owns the read response due next cycle
//   *_DEF         : default address/data widths and starvation limit
//   sat_inc16     : saturating increment for 16-bit event counters
package mem_arb_pkg;

   localparam int ADDR_W_DEF     = 10;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation counter.
//   clk1, rst_n : clock and asynchronous active-low reset
//   req         : fetch request pending this cycle
//   gnt         : fetch granted this cycle
//   force_win   : counter has reached STARVE_MAX, so fetch must win now
// The counter climbs on every cycle fetch asks but loses, saturates at
// STARVE_MAX and clears whenever fetch is granted or stops asking.
module mem_arb_starve_ctr #(
   parameter  int STARVE_MAX = 4,
   localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic req,
   input  logic gnt,
   output logic force_win
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;

   // Next count: grow while denied, hold at the limit, clear otherwise.
   always_comb begin
      cnt_next_s = '0;
      if (req && !gnt) begin
         if (cnt_r == MAX_C) begin
            cnt_next_s = cnt_r;
         end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_next_s = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   assign force_win = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// data (load/store) accesses.
//   clk1, rst_n                      : clock, async active-low reset
//   if_req/if_addr -> if_gnt         : fetch request and same-cycle grant
//   if_rvalid/if_rdata               : fetch response, one cycle after grant
//   dm_req/dm_we/dm_addr/dm_wdata    : data request (store when dm_we=1)
//   dm_gnt, dm_rvalid/dm_rdata       : data grant and load response
//   flush                            : kill fetch grant/response this cycle
//   halted                           : no new grants; responses still finish
//   mem_en/mem_we/mem_addr/mem_wdata : memory command, driven by the winner
//   mem_rdata                        : memory read data (1-cycle latency)
//   conflict_cnt                     : saturating count of both-request cycles
// Grants and the memory command are combinational from this cycle's
// requests; the response owner is a registered two-process FSM.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   input  logic              flush,
   input  logic              halted,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       conflict_cnt
);

   owner_e            owner_r;
   owner_e            owner_next_s;
   logic              force_win_s;
   logic              if_gnt_s;
   logic              dm_gnt_s;
   logic              if_rvalid_s;
   logic              dm_rvalid_s;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] dm_rdata_r;
   logic [15:0]       conflict_r;

   mem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .req       (if_req),
      .gnt       (if_gnt_s),
      .force_win (force_win_s)
   );

   // Arbitration: data wins unless fetch has starved long enough. A flushed
   // fetch is not eligible, so a forced fetch under flush yields to data.
   // Grants are gated by rst_n so nothing is issued while held in reset.
   always_comb begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
      if (!rst_n || halted) begin
         if_gnt_s = 1'b0;
         dm_gnt_s = 1'b0;
      end else if (force_win_s && if_req && !flush) begin
         if_gnt_s = 1'b1;
      end else if (dm_req) begin
         dm_gnt_s = 1'b1;
      end else if (if_req && !flush) begin
         if_gnt_s = 1'b1;
      end else begin
         if_gnt_s = 1'b0;
         dm_gnt_s = 1'b0;
      end
   end

   // Memory command from the winner; idle cycles drive zeros.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dm_gnt_s) begin
         mem_en    = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt_s) begin
         mem_en    = 1'b1;
         mem_we    = 1'b0;
         mem_addr  = if_addr;
         mem_wdata = '0;
      end else begin
         mem_en    = 1'b0;
      end
   end

   // Owner next state: stores expect no response, so they leave it NONE.
   always_comb begin
      owner_next_s = OWN_NONE;
      if (if_gnt_s) begin
         owner_next_s = OWN_IF;
      end else if (dm_gnt_s && !dm_we) begin
         owner_next_s = OWN_DM;
      end else begin
         owner_next_s = OWN_NONE;
      end
   end

   // Owner state register; reset drops any outstanding response.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         owner_r <= OWN_NONE;
      end else begin
         owner_r <= owner_next_s;
      end
   end

   // Response valids decoded from the owner; flush kills a fetch response.
   always_comb begin
      if_rvalid_s = 1'b0;
      dm_rvalid_s = 1'b0;
      case (owner_r)
         OWN_IF:   if_rvalid_s = !flush;
         OWN_DM:   dm_rvalid_s = 1'b1;
         OWN_NONE: begin
            if_rvalid_s = 1'b0;
            dm_rvalid_s = 1'b0;
         end
         default: begin
            if_rvalid_s = 1'b0;
            dm_rvalid_s = 1'b0;
         end
      endcase
   end

   // Hold registers keep the last delivered word between responses.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         if_rdata_r <= '0;
         dm_rdata_r <= '0;
      end else begin
         if (if_rvalid_s) begin
            if_rdata_r <= mem_rdata;
         end
         if (dm_rvalid_s) begin
            dm_rdata_r <= mem_rdata;
         end
      end
   end

   // Saturating count of cycles where both sides asked at once.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         conflict_r <= 16'd0;
      end else if (if_req && dm_req) begin
         conflict_r <= sat_inc16(conflict_r);
      end
   end

   assign if_gnt       = if_gnt_s;
   assign dm_gnt       = dm_gnt_s;
   assign if_rvalid    = if_rvalid_s;
   assign dm_rvalid    = dm_rvalid_s;
   assign if_rdata     = if_rvalid_s ? mem_rdata : if_rdata_r;
   assign dm_rdata     = dm_rvalid_s ? mem_rdata : dm_rdata_r;
   assign conflict_cnt = conflict_r;

endmodule
